apb_param_mem_slave: RTL and testbench

//  Parametrised APB (v4-style) memory slave: word-addressed RAM of DEPTH x DATA_W

---
 rtl/apb_param_mem_slave.sv | 82 ++++++++
 tb/tb_apb_param_mem_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_param_mem_slave.sv
// apb_param_mem_slave: APB word-addressed RAM with byte strobes, wait states and range error
module apb_param_mem_slave #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                P_clk,
    input  logic                P_reset_n,
    input  logic                P_sel,
    input  logic                P_enable,
    input  logic                P_write,
    input  logic [ADDR_W-1:0]   P_addr,
    input  logic [DATA_W-1:0]   P_wdata,
    input  logic [DATA_W/8-1:0] P_strb,
    output logic [DATA_W-1:0]   P_rdata,
    output logic                P_ready,
    output logic                P_slverr
);
    localparam int NB = DATA_W / 8;
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              slverr_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              access;
    logic              exec;
    logic              err;
    logic [IDX_W-1:0]  idx;
    assign access = P_sel & P_enable;
    assign err = {1'b0, P_addr} >= DEPTH_L;
    assign idx = P_addr[IDX_W-1:0];
    // exec is gated by reset so an access in flight never reaches the array
    assign exec = P_reset_n & (state_q == IDLE ? access & ~ready_q & (WAIT_STATES == 0)
                                               : state_q == WAIT & P_sel & (cnt_q == 4'd0));
    assign P_rdata = rdata_q;
    assign P_ready = ready_q;
    assign P_slverr = slverr_q;
    // Transfer FSM with registered response outputs
    always_ff @(posedge P_clk or negedge P_reset_n) begin
        if (!P_reset_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            slverr_q <= 1'b0;
        end else begin
            if (exec) begin
                ready_q <= 1'b1;
                slverr_q <= err;
                if (!P_write) rdata_q <= err ? '0 : mem_q[idx];
            end
            case (state_q)
                IDLE: if (access && !ready_q) begin
                    state_q <= WAIT_STATES == 0 ? RESP : WAIT;
                    cnt_q <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
                end
                WAIT: begin
                    if (!P_sel) state_q <= IDLE;
                    else if (cnt_q == 4'd0) state_q <= RESP;
                    else cnt_q <= cnt_q - 4'd1;
                end
                RESP: begin
                    ready_q <= 1'b0;
                    slverr_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    // Byte-strobed memory write; the array itself is never reset
    always_ff @(posedge P_clk) begin
        if (exec && P_write && !err)
            for (int i = 0; i < NB; i++)
                if (P_strb[i]) mem_q[idx][8*i +: 8] <= P_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_apb_param_mem_slave.sv
// tb_apb_param_mem_slave: two slave configurations (WS=0/DEPTH=256, WS=3/DEPTH=200) vs a reference model
module tb_apb_param_mem_slave;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    logic        sel [2];
    logic        en [2];
    logic        wr [2];
    logic [7:0]  addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb [2];
    logic [31:0] rdata [2];
    logic        ready [2];
    logic        slverr [2];
    int checks = 0;
    int errors = 0;
    logic [31:0] mdata [2][256];
    logic [3:0]  mknown [2][256];
    logic [31:0] last_exp [2];
    logic [3:0]  last_mask [2];
    logic        prev_rdy [2];
    bit          mon_on = 0;

    apb_param_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0)) dut0 (
        .P_clk(clk), .P_reset_n(rst_n), .P_sel(sel[0]), .P_enable(en[0]), .P_write(wr[0]),
        .P_addr(addr[0]), .P_wdata(wdata[0]), .P_strb(strb[0]), .P_rdata(rdata[0]),
        .P_ready(ready[0]), .P_slverr(slverr[0]));
    apb_param_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(3)) dut1 (
        .P_clk(clk), .P_reset_n(rst_n), .P_sel(sel[1]), .P_enable(en[1]), .P_write(wr[1]),
        .P_addr(addr[1]), .P_wdata(wdata[1]), .P_strb(strb[1]), .P_rdata(rdata[1]),
        .P_ready(ready[1]), .P_slverr(slverr[1]));

    function automatic int depth_of(input int d);
        return d == 1 ? 200 : 256;
    endfunction
    function automatic int ws_of(input int d);
        return d == 1 ? 3 : 0;
    endfunction
    function automatic logic [31:0] bmask(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    // P_ready must never be high on two consecutive cycles
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mon_on) begin
                checks++;
                if (ready[d] && prev_rdy[d]) begin
                    errors++;
                    $display("FAIL ready_twice dut%0d: ready high two cycles, required one", d);
                end
            end
            prev_rdy[d] = ready[d];
        end
    end

    // One full APB transfer: setup cycle, access phase until P_ready, then bus released
    task automatic apb(input int d, input bit w, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output logic [31:0] rd, output logic er,
                       output int lat, output logic rdy_after, output logic err_after);
        sel[d] = 1; en[d] = 0; wr[d] = w; addr[d] = a; wdata[d] = wd; strb[d] = s;
        @(posedge clk); #1 en[d] = 1;
        lat = 0; rd = '0; er = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (ready[d]) begin
                lat = k; rd = rdata[d]; er = slverr[d];
                break;
            end
        end
        checks++;
        if (lat == 0) begin
            errors++;
            $display("FAIL timeout dut%0d addr=%h: no P_ready within 40 cycles", d, a);
        end
        @(posedge clk); #1;
        rdy_after = ready[d]; err_after = slverr[d];
        sel[d] = 0; en[d] = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            checks += 3;
            if (rdata[d] !== 32'h0) begin errors++; $display("FAIL reset_rdata dut%0d got=%h exp=0", d, rdata[d]); end
            if (ready[d] !== 1'b0) begin errors++; $display("FAIL reset_ready dut%0d got=%b exp=0", d, ready[d]); end
            if (slverr[d] !== 1'b0) begin errors++; $display("FAIL reset_slverr dut%0d got=%b exp=0", d, slverr[d]); end
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        mon_on = 1;
    endtask

    task automatic test_basic();
        logic [31:0] rd; logic er, ra, ea; int lat;
        apb(0, 1, 8'h05, 32'hDEADBEEF, 4'hF, rd, er, lat, ra, ea);
        checks += 2;
        if (lat != 2) begin errors++; $display("FAIL basic_wr_lat got=%0d exp=2", lat); end
        if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got=%b exp=0", er); end
        apb(0, 0, 8'h05, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks += 4;
        if (lat != 2) begin errors++; $display("FAIL basic_rd_lat got=%0d exp=2", lat); end
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err got=%b exp=0", er); end
        if (ra !== 1'b0) begin errors++; $display("FAIL basic_ready_pulse got=%b exp=0", ra); end
    endtask

    task automatic test_strobe();
        logic [31:0] rd; logic er, ra, ea; int lat;
        apb(0, 1, 8'h10, 32'h11223344, 4'hF, rd, er, lat, ra, ea);
        apb(0, 1, 8'h10, 32'hAABBCCDD, 4'b0101, rd, er, lat, ra, ea);
        apb(0, 0, 8'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_merge got=%h exp=11bb33dd", rd); end
        apb(0, 1, 8'h10, 32'h55555555, 4'h0, rd, er, lat, ra, ea);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL strobe_zero_err got=%b exp=0", er); end
        apb(0, 0, 8'h10, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strobe_zero_noop got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_wait();
        logic [31:0] rd; logic er, ra, ea; int lat;
        apb(1, 1, 8'h40, 32'h12345678, 4'hF, rd, er, lat, ra, ea);
        checks++;
        if (lat != 5) begin errors++; $display("FAIL wait_wr_lat got=%0d exp=5", lat); end
        apb(1, 0, 8'h40, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks += 3;
        if (lat != 5) begin errors++; $display("FAIL wait_rd_lat got=%0d exp=5", lat); end
        if (ra !== 1'b0) begin errors++; $display("FAIL wait_ready_pulse got=%b exp=0", ra); end
        if (rd !== 32'h12345678) begin errors++; $display("FAIL wait_rd_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er, ra, ea; int lat;
        apb(1, 1, 8'hC7, 32'hCAFEF00D, 4'hF, rd, er, lat, ra, ea);
        apb(1, 0, 8'hC7, 32'h0, 4'h0, rd, er, lat, ra, ea);
        apb(1, 1, 8'hC8, 32'hFFFFFFFF, 4'hF, rd, er, lat, ra, ea);
        checks += 3;
        if (er !== 1'b1) begin errors++; $display("FAIL range_wr_err got=%b exp=1", er); end
        if (ea !== 1'b0) begin errors++; $display("FAIL range_wr_err_after got=%b exp=0", ea); end
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL range_wr_hold got=%h exp=cafef00d", rd); end
        apb(1, 0, 8'hC8, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks += 3;
        if (er !== 1'b1) begin errors++; $display("FAIL range_rd_err got=%b exp=1", er); end
        if (rd !== 32'h0) begin errors++; $display("FAIL range_rd_data got=%h exp=0", rd); end
        if (ea !== 1'b0) begin errors++; $display("FAIL range_rd_err_after got=%b exp=0", ea); end
        apb(1, 0, 8'hC7, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks += 2;
        if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL range_neighbour got=%h exp=cafef00d", rd); end
        if (er !== 1'b0) begin errors++; $display("FAIL range_neighbour_err got=%b exp=0", er); end
        apb(0, 1, 8'hFF, 32'hA5A5A5A5, 4'hF, rd, er, lat, ra, ea);
        apb(0, 0, 8'hFF, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks += 2;
        if (er !== 1'b0) begin errors++; $display("FAIL range_full_err got=%b exp=0", er); end
        if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL range_full_data got=%h exp=a5a5a5a5", rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic er, ra, ea; int lat;
        sel[1] = 1; en[1] = 0; wr[1] = 1; addr[1] = 8'h40; wdata[1] = 32'hFFFFFFFF; strb[1] = 4'hF;
        @(posedge clk); #1 en[1] = 1;
        repeat (2) @(posedge clk);
        #1 sel[1] = 0; en[1] = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (ready[1] !== 1'b0) begin errors++; $display("FAIL abort_ready cyc%0d got=%b exp=0", k, ready[1]); end
        end
        @(posedge clk); #1;
        apb(1, 0, 8'h40, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_mem got=%h exp=12345678", rd); end
        sel[1] = 1; en[1] = 0; wr[1] = 1; addr[1] = 8'h40; wdata[1] = 32'h0; strb[1] = 4'hF;
        @(posedge clk); #1 en[1] = 1;
        @(posedge clk); #2 rst_n = 0;
        #1;
        checks += 4;
        if (rdata[1] !== 32'h0) begin errors++; $display("FAIL async_rst_rdata1 got=%h exp=0", rdata[1]); end
        if (rdata[0] !== 32'h0) begin errors++; $display("FAIL async_rst_rdata0 got=%h exp=0", rdata[0]); end
        if (ready[1] !== 1'b0) begin errors++; $display("FAIL async_rst_ready got=%b exp=0", ready[1]); end
        if (slverr[1] !== 1'b0) begin errors++; $display("FAIL async_rst_slverr got=%b exp=0", slverr[1]); end
        sel[1] = 0; en[1] = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        apb(1, 0, 8'h40, 32'h0, 4'h0, rd, er, lat, ra, ea);
        checks++;
        if (rd !== 32'h12345678) begin errors++; $display("FAIL rst_mem_kept got=%h exp=12345678", rd); end
    endtask

    task automatic test_back_to_back(input int d, input int n);
        logic [31:0] rd, wd, exp, m; logic er, ra, ea, w, exp_err; logic [7:0] a; logic [3:0] s; int lat;
        last_mask[d] = 4'h0;
        last_exp[d] = '0;
        for (int t = 0; t < n; t++) begin
            w = 1'($urandom_range(0, 1));
            a = d == 1 ? 8'($urandom_range(190, 215)) : 8'($urandom_range(48, 63));
            wd = $urandom;
            s = 4'($urandom_range(0, 15));
            apb(d, w, a, wd, s, rd, er, lat, ra, ea);
            exp_err = int'(a) >= depth_of(d);
            checks += 3;
            if (lat != ws_of(d) + 2) begin errors++; $display("FAIL rand_lat dut%0d t%0d got=%0d exp=%0d", d, t, lat, ws_of(d) + 2); end
            if (er !== exp_err) begin errors++; $display("FAIL rand_err dut%0d t%0d addr=%h got=%b exp=%b", d, t, a, er, exp_err); end
            if (ra !== 1'b0) begin errors++; $display("FAIL rand_ready_pulse dut%0d t%0d got=%b exp=0", d, t, ra); end
            if (!w) begin
                exp = exp_err ? 32'h0 : mdata[d][a];
                last_exp[d] = exp;
                last_mask[d] = exp_err ? 4'hF : mknown[d][a];
                m = bmask(last_mask[d]);
                checks++;
                if ((rd & m) !== (exp & m)) begin errors++; $display("FAIL rand_rdata dut%0d t%0d addr=%h got=%h exp=%h mask=%h", d, t, a, rd, exp, m); end
            end else begin
                m = bmask(last_mask[d]);
                checks++;
                if ((rd & m) !== (last_exp[d] & m)) begin errors++; $display("FAIL rand_hold dut%0d t%0d got=%h exp=%h mask=%h", d, t, rd, last_exp[d], m); end
                if (!exp_err)
                    for (int i = 0; i < 4; i++)
                        if (s[i]) begin
                            mdata[d][a][8*i +: 8] = wd[8*i +: 8];
                            mknown[d][a][i] = 1'b1;
                        end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            sel[d] = 0; en[d] = 0; wr[d] = 0; addr[d] = '0; wdata[d] = '0; strb[d] = '0;
            prev_rdy[d] = 0;
            for (int i = 0; i < 256; i++) begin
                mdata[d][i] = '0;
                mknown[d][i] = '0;
            end
        end
        test_reset();
        test_basic();
        test_strobe();
        test_wait();
        test_range();
        test_abort();
        test_back_to_back(0, 100);
        test_back_to_back(1, 100);
        mon_on = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
